debounce_edge_fsm: RTL
======================

# debounce_edge_fsm

Debounces one raw mechanical input and produces a clean level plus single-cycle rise/fall pulses. It sits directly upstream of the team's parameterized tick timer. It drives that timer's enable and consumes its `timer_done` as the sampling tick. A change on the input is accepted only after it has held for `STABLE_TICKS` consecutive timer ticks.

## Interface
- `STABLE_TICKS`, default 3: consecutive ticks the synchronized input must hold at the new level before acceptance. Legal range 1..255.
- `SYNC_STAGES`, default 2: depth of the input synchronizer flop chain. Minimum 2.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous reset, active-low.
- `sw` input 1: raw, asynchronous, bouncing input.
- `timer_done` input 1: tick from the timer; high for one enabled cycle per period.
- `timer_en` output 1: enable to the timer.
- `db_level` output 1: debounced level.
- `db_rise` output 1: one-cycle pulse on accepted 0→1.
- `db_fall` output 1: one-cycle pulse on accepted 1→0.

## Operation
- **Synchronizer:** `sw` passes through a `SYNC_STAGES` flop chain; the last stage is `s`. All FSM decisions use `s` only.
- **Tick:** `tick = timer_done & timer_en`. A `timer_done` seen while `timer_en` is low is ignored.
- **Tick counter:** `cnt`, width `$clog2(STABLE_TICKS+1)`. It never exceeds `STABLE_TICKS-1`.
- **FSM states and transitions:**
  - **LOW:** if `s`=1, go to WAIT_HIGH with `cnt`=0.
  - **WAIT_HIGH:** if `s`=0, go to LOW (abort). Otherwise, on `tick`:
    - if `cnt`==`STABLE_TICKS-1`, go to HIGH;
    - else increment `cnt`.
  - **HIGH:** if `s`=0, go to WAIT_LOW with `cnt`=0.
  - **WAIT_LOW:** if `s`=1, go to HIGH (abort). Otherwise, on `tick`:
    - if `cnt`==`STABLE_TICKS-1`, go to LOW;
    - else increment `cnt`.
- **Priority:** abort wins over a simultaneous final tick. The level is not accepted and no pulse is produced.
- **Outputs:**
  - `timer_en` is high exactly in WAIT_HIGH and WAIT_LOW. The timer holds its count otherwise.
  - `db_level` is 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH.
  - `db_rise`/`db_fall` are registered and high for exactly the first cycle of HIGH/LOW after an accepted transition. They are never both high.
- **Reset values:** all of these are 0:
  - state LOW, `cnt`, synchronizer flops;
  - `timer_en`, `db_level`, `db_rise`, `db_fall`.
- **Reset mid-operation:** `reset_n` low at any time forces the reset values asynchronously. No pulse is emitted on reset or on release. If `sw` is high after release, a full debounce runs and then `db_rise` pulses once.

## Timing
- **Input to FSM:** a `sw` change sampled at edge k appears on `s` after edge k+SYNC_STAGES-1. The FSM enters the WAIT state at edge k+SYNC_STAGES.
- **Fresh timer** (count 0, period P = end_at+1):
  - The accepting transition occurs STABLE_TICKS·P edges after `timer_en` rises.
  - `db_level` changes and the pulse asserts on that same edge.
- **Timer not at 0 on WAIT entry:** the first tick arrives early. Acceptance latency after `timer_en` rises lies in [(STABLE_TICKS-1)·P+1, STABLE_TICKS·P] edges; this range is specified behaviour.
- **STABLE_TICKS=1:** the first tick accepts.
- **Pulse spacing:** no two pulses closer than STABLE_TICKS·P-(P-1) cycles.

## Test plan
All scenarios use a bench-instantiated timer with end_at=9 (P=10), STABLE_TICKS=3, SYNC_STAGES=2.
- **Reset:** assert `reset_n` low with `sw`=1 → all outputs 0 during reset. After release:
  - WAIT_HIGH is entered;
  - exactly one `db_rise` occurs 30 edges after `timer_en` rises.
- **Clean press from reset:** `sw` 0→1 sampled at edge k →
  - `timer_en`=1 from edge k+2;
  - `db_level`=1 and `db_rise`=1 for one cycle at edge k+32;
  - `timer_en`=0 after it.
- **Bounce:** `sw` toggles every 3 cycles for 40 cycles, then held 1 →
  - no `db_rise`/`db_fall` during bouncing;
  - exactly one `db_rise`, within 21..30 edges after `timer_en` last rises.
- **Release:** from HIGH, `sw` 1→0 held → `db_fall` one cycle, `db_level`=0, same latency window. No `db_rise` occurs.
- **Abort on final tick:** force `s`=0 in the cycle of the third tick in WAIT_HIGH → state returns to LOW, `db_level` stays 0, no pulse.
- **Reset mid-wait:** pulse `reset_n` low during WAIT_LOW → `db_level`=0 immediately, no `db_fall`, `timer_en`=0.

Source files
------------

// File: rtl/debounce_edge_fsm.sv
// Debouncer with synchronizer, tick-qualified stability count and
// registered level plus single-cycle rise/fall pulses.
module debounce_edge_fsm #(
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  input  logic timer_done,
  output logic timer_en,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;
  logic                   tick;

  assign s    = sync_q[SYNC_STAGES-1];
  assign tick = timer_done & en_q;

  // Abort on s is tested before the tick so it wins a final-tick race.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = LOW;
        end else if (tick) begin
          if (cnt_q == LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = HIGH;
        end else if (tick) begin
          if (cnt_q == LAST) begin
            state_d = LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    en_d  = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    lvl_d = (state_d == HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign timer_en = en_q;
  assign db_level = lvl_q;
  assign db_rise  = rise_q;
  assign db_fall  = fall_q;

endmodule
